// File: rtl/tlk_frame_rx.sv
// TLK receive framer: hunts for SOF once the link is valid, checks frame length and
// checksum, and streams header/payload/trailer words through an output FIFO.
module tlk_frame_rx #(
    parameter int                DATA_W     = 16,
    parameter int                FRAME_LEN  = 64,
    parameter logic [DATA_W-1:0] SOF_WORD   = 16'hBC50,
    parameter int                FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              LIVE,
    input  logic              dval,
    input  logic              tlk_err,
    input  logic [DATA_W-1:0] tlk_rxd,
    input  logic [1:0]        tlk_rx_k,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sof,
    output logic              out_eof,
    output logic              out_bad,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       frame_cnt,
    output logic [7:0]        err_cnt,
    output logic              fifo_ovf
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FRAME_LEN + 1);
    localparam int EW = DATA_W + 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HUNT    = 3'd1,
        ST_HEADER  = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_TRAILER = 3'd4
    } state_t;

    state_t            state_r;
    state_t            state_nx_s;
    logic [DATA_W-1:0] rxd_r;
    logic [1:0]        k_r;
    logic              err_r;
    logic [DATA_W-1:0] sum_r;
    logic [CW-1:0]     cnt_r;
    logic [15:0]       frame_cnt_r;
    logic [7:0]        err_cnt_r;

    logic              sof_hit_s;
    logic              abort_s;
    logic              in_frame_s;
    logic              last_pay_s;
    logic              chk_bad_s;
    logic              push_s;
    logic              good_s;
    logic              bad_s;
    logic [EW-1:0]     push_entry_s;

    // FIFO entries are {bad, eof, sof, data}
    logic [EW-1:0]     mem_r [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [AW:0]       count_r;
    logic              full_s;
    logic              pop_s;
    logic              wr_en_s;
    logic              drop_s;
    logic [AW:0]       remain_s;
    logic [AW-1:0]     head_addr_s;
    logic [DATA_W-1:0] out_data_r;
    logic              out_sof_r;
    logic              out_eof_r;
    logic              out_bad_r;
    logic              out_valid_r;
    logic              fifo_ovf_r;

    assign sof_hit_s  = (rxd_r == SOF_WORD) && (k_r == 2'b01) && !err_r;
    assign abort_s    = (k_r != 2'b00) || err_r || !dval;
    assign in_frame_s = (state_r == ST_HEADER) || (state_r == ST_PAYLOAD) || (state_r == ST_TRAILER);
    assign last_pay_s = (cnt_r == CW'(FRAME_LEN - 1));
    assign chk_bad_s  = (rxd_r != sum_r);

    // Single input retiming stage for the TLK bus
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rxd_r <= {DATA_W{1'b0}};
            k_r   <= 2'b00;
            err_r <= 1'b0;
        end else if (!LIVE) begin
            rxd_r <= {DATA_W{1'b0}};
            k_r   <= 2'b00;
            err_r <= 1'b0;
        end else begin
            rxd_r <= tlk_rxd;
            k_r   <= tlk_rx_k;
            err_r <= tlk_err;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else if (!LIVE) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next state; losing dval always returns to IDLE, otherwise an abort wins over length
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (dval) state_nx_s = ST_HUNT;
                else      state_nx_s = ST_IDLE;
            end
            ST_HUNT: begin
                if (!dval)          state_nx_s = ST_IDLE;
                else if (sof_hit_s) state_nx_s = ST_HEADER;
                else                state_nx_s = ST_HUNT;
            end
            ST_HEADER: begin
                if (!dval)        state_nx_s = ST_IDLE;
                else if (abort_s) state_nx_s = ST_HUNT;
                else              state_nx_s = ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                if (!dval)           state_nx_s = ST_IDLE;
                else if (abort_s)    state_nx_s = ST_HUNT;
                else if (last_pay_s) state_nx_s = ST_TRAILER;
                else                 state_nx_s = ST_PAYLOAD;
            end
            ST_TRAILER: begin
                if (!dval) state_nx_s = ST_IDLE;
                else       state_nx_s = ST_HUNT;
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // FSM outputs: FIFO push request and frame verdicts
    always_comb begin
        push_s       = 1'b0;
        push_entry_s = {EW{1'b0}};
        good_s       = 1'b0;
        bad_s        = 1'b0;
        if (in_frame_s && abort_s) begin
            push_s       = 1'b1;
            push_entry_s = {1'b1, 1'b1, 1'b0, {DATA_W{1'b0}}};
            bad_s        = 1'b1;
        end else begin
            case (state_r)
                ST_HEADER: begin
                    push_s       = 1'b1;
                    push_entry_s = {3'b001, rxd_r};
                end
                ST_PAYLOAD: begin
                    push_s       = 1'b1;
                    push_entry_s = {3'b000, rxd_r};
                end
                ST_TRAILER: begin
                    push_s       = 1'b1;
                    push_entry_s = {chk_bad_s, 2'b10, rxd_r};
                    good_s       = !chk_bad_s;
                    bad_s        = chk_bad_s;
                end
                default: begin
                    push_s = 1'b0;
                end
            endcase
        end
    end

    // Running checksum (header included) and payload word count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_r <= {DATA_W{1'b0}};
            cnt_r <= {CW{1'b0}};
        end else if (!LIVE) begin
            sum_r <= {DATA_W{1'b0}};
            cnt_r <= {CW{1'b0}};
        end else if (state_r == ST_HEADER) begin
            sum_r <= rxd_r;
            cnt_r <= {CW{1'b0}};
        end else if (state_r == ST_PAYLOAD) begin
            sum_r <= sum_r + rxd_r;
            cnt_r <= cnt_r + CW'(1'b1);
        end else begin
            sum_r <= sum_r;
            cnt_r <= cnt_r;
        end
    end

    // Frame statistics survive a LIVE flush; only reset clears them
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt_r <= 16'h0000;
            err_cnt_r   <= 8'h00;
        end else if (!LIVE) begin
            frame_cnt_r <= frame_cnt_r;
            err_cnt_r   <= err_cnt_r;
        end else begin
            if (good_s) frame_cnt_r <= frame_cnt_r + 16'h0001;
            if (bad_s && (err_cnt_r != 8'hFF)) err_cnt_r <= err_cnt_r + 8'h01;
        end
    end

    assign full_s      = (count_r == (AW + 1)'(FIFO_DEPTH));
    assign pop_s       = out_valid_r && out_ready;
    assign wr_en_s     = push_s && (!full_s || pop_s);
    assign drop_s      = push_s && full_s && !pop_s;
    assign remain_s    = count_r - (AW + 1)'(pop_s);
    assign head_addr_s = rd_ptr_r + AW'(pop_s);

    // FIFO storage
    always_ff @(posedge clk) begin
        if (wr_en_s) mem_r[wr_ptr_r] <= push_entry_s;
    end

    // FIFO pointers, overflow flag and the registered view of the head entry
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            count_r     <= {(AW + 1){1'b0}};
            fifo_ovf_r  <= 1'b0;
            out_valid_r <= 1'b0;
            {out_bad_r, out_eof_r, out_sof_r, out_data_r} <= {EW{1'b0}};
        end else if (!LIVE) begin
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            count_r     <= {(AW + 1){1'b0}};
            fifo_ovf_r  <= 1'b0;
            out_valid_r <= 1'b0;
            {out_bad_r, out_eof_r, out_sof_r, out_data_r} <= {EW{1'b0}};
        end else begin
            wr_ptr_r   <= wr_ptr_r + AW'(wr_en_s);
            rd_ptr_r   <= rd_ptr_r + AW'(pop_s);
            count_r    <= count_r + (AW + 1)'(wr_en_s) - (AW + 1)'(pop_s);
            fifo_ovf_r <= fifo_ovf_r | drop_s;
            // The head entry stays in storage until popped, so it counts against depth
            if (remain_s != {(AW + 1){1'b0}}) begin
                out_valid_r <= 1'b1;
                {out_bad_r, out_eof_r, out_sof_r, out_data_r} <= mem_r[head_addr_s];
            end else begin
                out_valid_r <= 1'b0;
                {out_bad_r, out_eof_r, out_sof_r, out_data_r} <= {EW{1'b0}};
            end
        end
    end

    assign out_data  = out_data_r;
    assign out_sof   = out_sof_r;
    assign out_eof   = out_eof_r;
    assign out_bad   = out_bad_r;
    assign out_valid = out_valid_r;
    assign frame_cnt = frame_cnt_r;
    assign err_cnt   = err_cnt_r;
    assign fifo_ovf  = fifo_ovf_r;

endmodule

// File: tb/tb_tlk_frame_rx.sv
// Scoreboard bench for tlk_frame_rx: frame-level reference model feeds an expected-word
// queue; an independent monitor compares every accepted output word.
module tb_tlk_frame_rx;

    localparam logic [15:0] SOF = 16'hBC50;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        LIVE;
    logic        dval;
    logic        tlk_err;
    logic [15:0] tlk_rxd;
    logic [1:0]  tlk_rx_k;
    logic [15:0] out_data;
    logic        out_sof;
    logic        out_eof;
    logic        out_bad;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;
    logic        fifo_ovf;

    always #5 clk = ~clk;

    tlk_frame_rx dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .LIVE      (LIVE),
        .dval      (dval),
        .tlk_err   (tlk_err),
        .tlk_rxd   (tlk_rxd),
        .tlk_rx_k  (tlk_rx_k),
        .out_data  (out_data),
        .out_sof   (out_sof),
        .out_eof   (out_eof),
        .out_bad   (out_bad),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_cnt (frame_cnt),
        .err_cnt   (err_cnt),
        .fifo_ovf  (fifo_ovf)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          ready_mode = 0;
    logic        lat_en = 1'b0;
    logic [18:0] exp_q[$];
    logic [15:0] frm[66];
    logic [15:0] exp_frame = 16'h0000;
    int          exp_errc = 0;
    event        hdr_ev;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Consumer ready pattern
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
        #2;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ((cyc % 16) != 7);
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor: every accepted word is compared with the head of the expected queue
    initial forever begin
        @(negedge clk);
        if (reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_word: got %0h expected none", {out_bad, out_eof, out_sof, out_data});
            end else begin
                check("stream_word", {13'd0, out_bad, out_eof, out_sof, out_data}, {13'd0, exp_q.pop_front()});
            end
        end
    end

    // Header-to-first-output latency probe
    initial forever begin
        @(hdr_ev);
        if (lat_en) begin
            lat_en = 1'b0;
            @(posedge clk);
            @(posedge clk);
            #1 check("lat_valid_n1", {31'd0, out_valid}, 32'd0);
            @(posedge clk);
            #1 check("lat_valid_n2", {31'd0, out_valid}, 32'd1);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic drv(input logic [15:0] d, input logic [1:0] k, input logic e, input logic dv);
        @(posedge clk);
        #1;
        tlk_rxd  = d;
        tlk_rx_k = k;
        tlk_err  = e;
        dval     = dv;
    endtask

    task automatic gap(input int n);
        logic [15:0] d;
        logic [1:0]  k;
        logic        e;
        for (int i = 0; i < n; i++) begin
            d = 16'($urandom);
            k = 2'($urandom);
            e = ($urandom_range(0, 7) == 0);
            if (d == SOF && k == 2'b01 && !e) d = d ^ 16'h0001;
            drv(d, k, e, 1'b1);
        end
    endtask

    function automatic void err_inc();
        exp_errc = (exp_errc >= 255) ? 255 : exp_errc + 1;
    endfunction

    task automatic fill_count();
        frm[0] = 16'h0001;
        for (int i = 1; i <= 64; i++) frm[i] = 16'(i);
        frm[65] = 16'h0821;
    endtask

    task automatic fill_rand(input logic good);
        logic [15:0] s;
        s = 16'h0000;
        for (int i = 0; i < 65; i++) begin
            frm[i] = 16'($urandom);
            s = s + frm[i];
        end
        frm[65] = good ? s : (s ^ 16'($urandom_range(1, 65535)));
    endtask

    // kind 0: complete frame, 2: K-char at pos, 3: err at pos, 4: dval drop at pos
    task automatic send_frame(input int kind, input int pos, input int keep);
        logic [15:0] s;
        logic [15:0] d;
        int          pushed;
        s = 16'h0000;
        pushed = 0;
        drv(SOF, 2'b01, 1'b0, 1'b1);
        for (int i = 0; i < 66; i++) begin
            if (kind != 0 && i == pos) begin
                d = 16'($urandom);
                if (d == SOF) d = d ^ 16'h0001;
                if (kind == 2) begin
                    drv(d, 2'($urandom_range(1, 3)), 1'b0, 1'b1);
                end else if (kind == 3) begin
                    drv(d, 2'($urandom), 1'b1, 1'b1);
                end else begin
                    drv(d, 2'b00, 1'b0, 1'b1);
                    drv(16'($urandom), 2'b00, 1'b0, 1'b0);
                    drv(16'($urandom), 2'b00, 1'b0, 1'b0);
                    drv(SOF, 2'b01, 1'b0, 1'b0);
                end
                if (pushed < keep) exp_q.push_back({1'b1, 1'b1, 1'b0, 16'h0000});
                err_inc();
                return;
            end
            drv(frm[i], 2'b00, 1'b0, 1'b1);
            if (i == 0) ->hdr_ev;
            if (i < 65) s = s + frm[i];
            if (pushed < keep) begin
                if (i == 65) exp_q.push_back({(frm[65] != s), 1'b1, 1'b0, frm[i]});
                else         exp_q.push_back({1'b0, 1'b0, (i == 0), frm[i]});
                pushed++;
            end
            if (i == 65) begin
                if (frm[65] == s) exp_frame = exp_frame + 16'h0001;
                else              err_inc();
            end
        end
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(posedge clk);
            t++;
        end
        repeat (4) @(posedge clk);
        check(name, exp_q.size(), 32'd0);
    endtask

    task automatic check_counters(input string name);
        check({name, "_frame_cnt"}, {16'd0, frame_cnt}, {16'd0, exp_frame});
        check({name, "_err_cnt"}, {24'd0, err_cnt}, 32'(exp_errc));
    endtask

    initial begin
        int kind;
        reset_n   = 1'b0;
        LIVE      = 1'b1;
        dval      = 1'b0;
        tlk_err   = 1'b0;
        tlk_rxd   = 16'h0000;
        tlk_rx_k  = 2'b00;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_word", {13'd0, out_bad, out_eof, out_sof, out_data}, 32'd0);
        check("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        check("rst_ovf", {31'd0, fifo_ovf}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Known-good counting frame with latency probe
        gap(3);
        fill_count();
        lat_en = 1'b1;
        send_frame(0, 0, 1000);
        drain("good_drain");
        check_counters("good");

        // Same frame with a zero trailer
        gap(2);
        frm[65] = 16'h0000;
        send_frame(0, 0, 1000);
        drain("badsum_drain");
        check_counters("badsum");

        // K-char inside the payload, then a good frame
        gap(2);
        fill_count();
        send_frame(2, 10, 1000);
        gap(3);
        send_frame(0, 0, 1000);
        drain("kabort_drain");
        check_counters("kabort");

        // dval drop mid-payload; a SOF while dval is low must be ignored
        gap(2);
        fill_rand(1'b1);
        send_frame(4, 30, 1000);
        gap(4);
        fill_rand(1'b1);
        send_frame(0, 0, 1000);
        drain("dvaldrop_drain");
        check_counters("dvaldrop");

        // Randomized mix under light backpressure
        ready_mode = 1;
        for (int f = 0; f < 40; f++) begin
            kind = $urandom_range(0, 4);
            fill_rand(kind != 1);
            gap($urandom_range(1, 12));
            send_frame((kind == 1) ? 0 : kind, $urandom_range(0, 65), 1000);
        end
        gap(2);
        ready_mode = 0;
        drain("random_drain");
        check_counters("random");
        check("random_ovf", {31'd0, fifo_ovf}, 32'd0);

        // Consumer stalled for a whole frame: first 16 words retained
        ready_mode = 2;
        repeat (2) @(posedge clk);
        gap(2);
        fill_rand(1'b1);
        send_frame(0, 0, 16);
        gap(4);
        #2;
        check("ovf_flag", {31'd0, fifo_ovf}, 32'd1);
        check("ovf_hold_valid", {31'd0, out_valid}, 32'd1);
        check("ovf_hold_word", {13'd0, out_bad, out_eof, out_sof, out_data}, {16'd0, 3'b001, frm[0]});
        ready_mode = 0;
        drain("ovf_drain");
        check_counters("ovf");

        // LIVE flush clears the stream state but keeps counters
        @(posedge clk);
        #1 LIVE = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("live_ovf", {31'd0, fifo_ovf}, 32'd0);
        check("live_valid", {31'd0, out_valid}, 32'd0);
        check_counters("live");
        LIVE = 1'b1;

        // Asynchronous reset in the middle of a frame
        gap(3);
        fill_count();
        drv(SOF, 2'b01, 1'b0, 1'b1);
        for (int i = 0; i <= 20; i++) begin
            drv(frm[i], 2'b00, 1'b0, 1'b1);
            exp_q.push_back({1'b0, 1'b0, (i == 0), frm[i]});
        end
        #2 reset_n = 1'b0;
        exp_q.delete();
        exp_frame = 16'h0000;
        exp_errc  = 0;
        #1;
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        check("arst_word", {13'd0, out_bad, out_eof, out_sof, out_data}, 32'd0);
        check_counters("arst");
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;

        // Error counter saturation with short aborted frames
        for (int f = 0; f < 260; f++) begin
            fill_rand(1'b1);
            gap(1);
            send_frame(2, 1, 1000);
        end
        gap(2);
        drain("sat_drain");
        check_counters("sat");
        check("sat_err_255", {24'd0, err_cnt}, 32'd255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
